// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron trainer and its core handshake.
package perceptron_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST,
    ST_LD_W0,
    ST_LD_W1,
    ST_LD_W2,
    ST_LD_N,
    ST_SEND_X1,
    ST_SEND_X2,
    ST_WAIT,
    ST_SAMPLE,
    ST_EPOCH,
    ST_RB_W0,
    ST_RB_W1,
    ST_RB_W2,
    ST_FIN
  } state_e;

  // Core output-mux selects.
  localparam logic [1:0] SEL_SUM = 2'd0;
  localparam logic [1:0] SEL_W2  = 2'd1;
  localparam logic [1:0] SEL_W1  = 2'd2;
  localparam logic [1:0] SEL_W0  = 2'd3;

  // 1.0 in the core's fixed-point format (3 fractional bits).
  localparam logic [5:0] ONE = 6'b001000;

  localparam int WD_LIMIT = 16;
  localparam int WD_W     = $clog2(WD_LIMIT);

  typedef struct packed {
    logic [5:0] x1;
    logic [5:0] x2;
    logic       label;
  } sample_t;

endpackage

// File: rtl/perceptron_trainer_if.sv
// Serial load / result handshake between the trainer (master) and the perceptron core (slave).
interface perceptron_core_if;
  logic       p_reset_l;
  logic       go;
  logic       update;
  logic       correct;
  logic [1:0] sel_out;
  logic [5:0] in_val;
  logic       done;
  logic       classification;
  logic       sync;
  logic [5:0] out_val;

  modport master (
    output p_reset_l, go, update, correct, sel_out, in_val,
    input  done, classification, sync, out_val
  );

  modport slave (
    input  p_reset_l, go, update, correct, sel_out, in_val,
    output done, classification, sync, out_val
  );
endinterface

// File: rtl/perceptron_trainer_sample_mem.sv
// Training-set register file: one write port, one combinational read port.
module sample_mem
  import perceptron_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sample_t       wdata,
  input  logic [AW-1:0] raddr,
  output sample_t       rdata
);

  sample_t mem [DEPTH];

  // NOTE: storage has no reset; the host writes every slot it uses before a run.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_trainer.sv
// Epoch sequencer for the perceptron core: loads weights/rate, streams samples, counts errors.
// Optional weight readback after the last epoch is built when PTRAIN_READBACK_EN is defined.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int MAX_EPOCHS = 15,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1,
  localparam int EW         = $clog2(MAX_EPOCHS + 1)
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              start,
  input  logic              train,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [5:0]        wr_x1,
  input  logic [5:0]        wr_x2,
  input  logic              wr_label,
  input  logic [CW-1:0]     num_samples,
  input  logic [5:0]        init_w0,
  input  logic [5:0]        init_w1,
  input  logic [5:0]        init_w2,
  input  logic [5:0]        init_n,
  perceptron_core_if.master core,
  output logic              busy,
  output logic              finished,
  output logic              converged,
  output logic [EW-1:0]     epochs,
  output logic [CW-1:0]     last_errors,
  output logic              proto_err,
  output logic [5:0]        w0_out,
  output logic [5:0]        w1_out,
  output logic [5:0]        w2_out
);

  state_e          state_q, state_d;
  logic            train_q;
  logic [5:0]      w0_q, w1_q, w2_q, n_q;
  logic [CW-1:0]   num_q, err_q, num_clamped;
  logic [AW-1:0]   idx_q;
  logic [WD_W-1:0] wd_q;
  sample_t         wr_sample, rd_sample;
  logic            last_sample, stop_run, wd_expire, sync_needed, label_phase;
  logic            go_c;
  logic [5:0]      in_val_c;
  logic [1:0]      sel_c;

  assign wr_sample = '{x1: wr_x1, x2: wr_x2, label: wr_label};

  sample_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en && (state_q == ST_IDLE)),
    .waddr (wr_addr),
    .wdata (wr_sample),
    .raddr (idx_q),
    .rdata (rd_sample)
  );

  assign num_clamped = (num_samples > CW'(DEPTH)) ? CW'(DEPTH) : num_samples;
  assign last_sample = ((CW'(idx_q) + CW'(1)) == num_q);
  assign stop_run    = (err_q == '0) || !train_q || (epochs == EW'(MAX_EPOCHS - 1));
  assign wd_expire   = (wd_q == WD_W'(WD_LIMIT - 1));
  assign sync_needed = state_q inside {ST_LD_W0, ST_LD_W1, ST_LD_W2, ST_LD_N, ST_SEND_X1};
  assign label_phase = state_q inside {ST_SEND_X1, ST_SEND_X2, ST_WAIT, ST_SAMPLE};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    go_c     = 1'b0;
    in_val_c = '0;
    sel_c    = SEL_SUM;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_RST;
      ST_RST:     state_d = ST_LD_W0;
      ST_LD_W0:   begin go_c = 1'b1; in_val_c = w0_q; state_d = ST_LD_W1; end
      ST_LD_W1:   begin go_c = 1'b1; in_val_c = w1_q; state_d = ST_LD_W2; end
      ST_LD_W2:   begin go_c = 1'b1; in_val_c = w2_q; state_d = ST_LD_N;  end
      ST_LD_N: begin
        go_c     = 1'b1;
        in_val_c = n_q;
        state_d  = (num_q == '0) ? ST_FIN : ST_SEND_X1;
      end
      ST_SEND_X1: begin go_c = 1'b1; in_val_c = rd_sample.x1; state_d = ST_SEND_X2; end
      ST_SEND_X2: begin go_c = 1'b1; in_val_c = rd_sample.x2; state_d = ST_WAIT;    end
      ST_WAIT: begin
        if (core.done)     state_d = ST_SAMPLE;
        else if (wd_expire) state_d = ST_FIN;
      end
      ST_SAMPLE:  state_d = last_sample ? ST_EPOCH : ST_SEND_X1;
      ST_EPOCH: begin
        if (!stop_run) begin
          state_d = ST_SEND_X1;
        end else begin
`ifdef PTRAIN_READBACK_EN
          state_d = ST_RB_W0;
`else
          state_d = ST_FIN;
`endif
        end
      end
`ifdef PTRAIN_READBACK_EN
      ST_RB_W0:   begin sel_c = SEL_W0; state_d = ST_RB_W1; end
      ST_RB_W1:   begin sel_c = SEL_W1; state_d = ST_RB_W2; end
      ST_RB_W2:   begin sel_c = SEL_W2; state_d = ST_FIN;   end
`endif
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      train_q     <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      n_q         <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      wd_q        <= '0;
      epochs      <= '0;
      last_errors <= '0;
      converged   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (sync_needed && !core.sync) proto_err <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            train_q     <= train;
            w0_q        <= init_w0;
            w1_q        <= init_w1;
            w2_q        <= init_w2;
            n_q         <= init_n;
            num_q       <= num_clamped;
            idx_q       <= '0;
            err_q       <= '0;
            epochs      <= '0;
            last_errors <= '0;
            converged   <= 1'b0;
            proto_err   <= 1'b0;
          end
        end
        ST_LD_N:    if (num_q == '0) converged <= 1'b1;
        ST_SEND_X2: wd_q <= '0;
        ST_WAIT: begin
          if (!core.done) begin
            wd_q <= wd_q + WD_W'(1);
            if (wd_expire) proto_err <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (core.classification != rd_sample.label) err_q <= err_q + CW'(1);
          idx_q <= last_sample ? '0 : idx_q + AW'(1);
        end
        // The core returns to its x1-ready state, so the next epoch skips the load phase.
        ST_EPOCH: begin
          epochs      <= epochs + EW'(1);
          last_errors <= err_q;
          converged   <= (err_q == '0);
          err_q       <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef PTRAIN_READBACK_EN
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      w0_out <= '0;
      w1_out <= '0;
      w2_out <= '0;
    end else begin
      case (state_q)
        ST_RB_W0: w0_out <= core.out_val;
        ST_RB_W1: w1_out <= core.out_val;
        ST_RB_W2: w2_out <= core.out_val;
        default: ;
      endcase
    end
  end
`else
  assign w0_out = '0;
  assign w1_out = '0;
  assign w2_out = '0;
`endif

  assign core.p_reset_l = (state_q != ST_RST);
  assign core.go        = go_c;
  assign core.in_val    = in_val_c;
  assign core.sel_out   = sel_c;
  assign core.update    = train_q && busy;
  assign core.correct   = label_phase && rd_sample.label;
  assign busy           = (state_q != ST_IDLE);
  assign finished       = (state_q == ST_FIN);

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer against a small behavioural perceptron core.
module tb_perceptron_trainer;
  import perceptron_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXE  = 3;
  localparam int AW    = 2;
  localparam int CW    = 3;
  localparam int EW    = 2;
  localparam int LAT   = 1;
`ifdef PTRAIN_READBACK_EN
  localparam int RB = 3;
`else
  localparam int RB = 0;
`endif
  localparam logic [5:0]  TR_W0_EXP = (RB != 0) ? 6'd8 : 6'd0;
  localparam logic [20:0] RST_EXP   = {1'b1, 20'd0};

  logic clk = 1'b0, reset_l = 1'b0, start = 1'b0, train = 1'b0, wr_en = 1'b0, wr_label = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [5:0]    wr_x1 = '0, wr_x2 = '0, init_w0 = '0, init_w1 = '0, init_w2 = '0, init_n = '0;
  logic [CW-1:0] num_samples = '0;
  logic          busy, finished, converged, proto_err;
  logic [EW-1:0] epochs;
  logic [CW-1:0] last_errors;
  logic [5:0]    w0_out, w1_out, w2_out;

  int compared = 0, mismatched = 0;
  int r_cycles, r_go, r_fin;
  logic stall = 1'b0, nosync_w1 = 1'b0;

  perceptron_core_if core_if();

  perceptron_trainer #(.DEPTH(DEPTH), .MAX_EPOCHS(MAXE)) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .train(train),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_label(wr_label),
    .num_samples(num_samples), .init_w0(init_w0), .init_w1(init_w1), .init_w2(init_w2),
    .init_n(init_n), .core(core_if), .busy(busy), .finished(finished), .converged(converged),
    .epochs(epochs), .last_errors(last_errors), .proto_err(proto_err),
    .w0_out(w0_out), .w1_out(w1_out), .w2_out(w2_out)
  );

  always #5 clk = ~clk;

  // Behavioural core: sync while accepting loads/x1, done after LAT+1 compute cycles.
  typedef enum {C_W0, C_W1, C_W2, C_N, C_RDY, C_X2, C_CALC, C_DONE} core_st_e;
  core_st_e cst = C_W0;
  logic signed [5:0] m_w0 = '0, m_w1 = '0, m_w2 = '0, m_n = '0, m_x1 = '0;
  logic m_cls = 1'b0;
  int   m_cnt = 0;

  function automatic logic signed [5:0] scale(input logic signed [5:0] a, input logic signed [5:0] b);
    int p;
    p = int'(a) * int'(b);
    return 6'(p >>> 3);
  endfunction

  always @(posedge clk) begin
    if (!core_if.p_reset_l) begin
      cst <= C_W0; m_w0 <= '0; m_w1 <= '0; m_w2 <= '0; m_n <= '0; m_cls <= 1'b0;
    end else begin
      case (cst)
        C_W0:  if (core_if.go) begin m_w0 <= core_if.in_val; cst <= C_W1;  end
        C_W1:  if (core_if.go) begin m_w1 <= core_if.in_val; cst <= C_W2;  end
        C_W2:  if (core_if.go) begin m_w2 <= core_if.in_val; cst <= C_N;   end
        C_N:   if (core_if.go) begin m_n  <= core_if.in_val; cst <= C_RDY; end
        C_RDY: if (core_if.go) begin m_x1 <= core_if.in_val; cst <= C_X2;  end
        C_X2: if (core_if.go) begin
          m_cls <= (int'(m_w0) + int'(scale(m_w1, m_x1)) + int'(scale(m_w2, core_if.in_val))) > 0;
          m_cnt <= LAT;
          cst   <= C_CALC;
        end
        C_CALC: if (!stall) begin
          if (m_cnt == 0) cst <= C_DONE;
          else m_cnt <= m_cnt - 1;
        end
        C_DONE: begin
          if (core_if.update && (m_cls != core_if.correct)) begin
            if (core_if.correct) begin
              m_w0 <= m_w0 + scale(m_n, ONE); m_w1 <= m_w1 + scale(m_n, m_x1); m_w2 <= m_w2 + scale(m_n, core_if.in_val);
            end else begin
              m_w0 <= m_w0 - scale(m_n, ONE); m_w1 <= m_w1 - scale(m_n, m_x1); m_w2 <= m_w2 - scale(m_n, core_if.in_val);
            end
          end
          cst <= C_RDY;
        end
        default: cst <= C_W0;
      endcase
    end
  end

  assign core_if.sync = (cst inside {C_W0, C_W1, C_W2, C_N, C_RDY}) && !(nosync_w1 && (cst == C_W1));
  assign core_if.done = (cst == C_DONE);
  assign core_if.classification = m_cls;
  assign core_if.out_val = (core_if.sel_out == SEL_W0) ? m_w0 :
                           (core_if.sel_out == SEL_W1) ? m_w1 :
                           (core_if.sel_out == SEL_W2) ? m_w2 : 6'd0;

  function automatic logic [20:0] reset_vec();
    return {core_if.p_reset_l, core_if.go, core_if.update, core_if.correct, core_if.sel_out,
            core_if.in_val, busy, finished, converged, epochs, last_errors, proto_err};
  endfunction

  task automatic write_slot(input logic [AW-1:0] a, input logic [5:0] x1, input logic [5:0] x2, input logic lb);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_x1 = x1; wr_x2 = x2; wr_label = lb;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a run and counts cycles to finished (start cycle = 0), go pulses and finished pulses.
  task automatic run(input logic tr, input logic [CW-1:0] ns, input logic [5:0] a, input logic [5:0] n,
                     input bit same_wr, input bit busy_poke);
    @(negedge clk);
    train = tr; num_samples = ns; init_w0 = a; init_w1 = '0; init_w2 = '0; init_n = n; start = 1'b1;
    if (same_wr) begin wr_en = 1'b1; wr_addr = 2'd3; wr_x1 = '0; wr_x2 = '0; wr_label = 1'b0; end
    r_cycles = 0; r_go = 0; r_fin = 0;
    while (r_cycles < 400) begin
      @(negedge clk);
      r_cycles++;
      start = 1'b0; wr_en = 1'b0;
      if (busy_poke && r_cycles == 3) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_label = 1'b0;
      end
      if (core_if.go) r_go++;
      if (finished) begin r_fin++; break; end
    end
    start = 1'b0; wr_en = 1'b0;
    compared++;
    if (finished !== 1'b1) begin mismatched++; $display("FAIL run_timeout cycles=%0d required finish within 400", r_cycles); end
    repeat (4) begin @(negedge clk); if (finished) r_fin++; end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (reset_vec() !== RST_EXP) begin mismatched++; $display("FAIL reset_outputs got=%h exp=%h", reset_vec(), RST_EXP); end
    compared++;
    if (w0_out !== 6'd0) begin mismatched++; $display("FAIL reset_w0_out got=%0d exp=0", w0_out); end
    reset_l = 1'b1;
  endtask

  task automatic test_inference();
    write_slot(2'd0, 6'd0, 6'd0, 1'b1);
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b0);
    compared++; if (r_go !== 6) begin mismatched++; $display("FAIL inf_go_count got=%0d exp=6", r_go); end
    compared++; if (r_cycles !== 13 + RB) begin mismatched++; $display("FAIL inf_latency got=%0d exp=%0d", r_cycles, 13 + RB); end
    compared++; if (converged !== 1'b1) begin mismatched++; $display("FAIL inf_converged got=%b exp=1", converged); end
    compared++; if (epochs !== 2'd1) begin mismatched++; $display("FAIL inf_epochs got=%0d exp=1", epochs); end
    compared++; if (last_errors !== 3'd0) begin mismatched++; $display("FAIL inf_errors got=%0d exp=0", last_errors); end
    compared++; if (proto_err !== 1'b0) begin mismatched++; $display("FAIL inf_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_training();
    write_slot(2'd0, 6'd8, 6'd0, 1'b1);
    run(1'b1, 3'd1, 6'd0, 6'd8, 1'b0, 1'b0);
    compared++; if (epochs !== 2'd2) begin mismatched++; $display("FAIL tr_epochs got=%0d exp=2", epochs); end
    compared++; if (converged !== 1'b1) begin mismatched++; $display("FAIL tr_converged got=%b exp=1", converged); end
    compared++; if (last_errors !== 3'd0) begin mismatched++; $display("FAIL tr_errors got=%0d exp=0", last_errors); end
    compared++; if (r_go !== 8) begin mismatched++; $display("FAIL tr_go_count got=%0d exp=8", r_go); end
    compared++; if (w0_out !== TR_W0_EXP) begin mismatched++; $display("FAIL tr_w0_out got=%0d exp=%0d", w0_out, TR_W0_EXP); end
    compared++; if (w1_out !== TR_W0_EXP) begin mismatched++; $display("FAIL tr_w1_out got=%0d exp=%0d", w1_out, TR_W0_EXP); end
  endtask

  task automatic test_non_separable();
    write_slot(2'd0, 6'd8, 6'd8, 1'b1);
    write_slot(2'd1, 6'd8, 6'd8, 1'b0);
    run(1'b1, 3'd2, 6'd0, 6'd8, 1'b0, 1'b0);
    compared++; if (epochs !== 2'd3) begin mismatched++; $display("FAIL ns_epochs got=%0d exp=3", epochs); end
    compared++; if (converged !== 1'b0) begin mismatched++; $display("FAIL ns_converged got=%b exp=0", converged); end
    compared++; if (last_errors !== 3'd2) begin mismatched++; $display("FAIL ns_errors got=%0d exp=2", last_errors); end
    compared++; if (r_fin !== 1) begin mismatched++; $display("FAIL ns_finished_pulses got=%0d exp=1", r_fin); end
    compared++; if (r_go !== 16) begin mismatched++; $display("FAIL ns_go_count got=%0d exp=16", r_go); end
  endtask

  task automatic test_zero_samples();
    run(1'b1, 3'd0, 6'd0, 6'd8, 1'b0, 1'b0);
    compared++; if (r_cycles !== 6) begin mismatched++; $display("FAIL zero_latency got=%0d exp=6", r_cycles); end
    compared++; if (converged !== 1'b1) begin mismatched++; $display("FAIL zero_converged got=%b exp=1", converged); end
    compared++; if (epochs !== 2'd0) begin mismatched++; $display("FAIL zero_epochs got=%0d exp=0", epochs); end
    compared++; if (r_go !== 4) begin mismatched++; $display("FAIL zero_go_count got=%0d exp=4", r_go); end
  endtask

  // num_samples=7 clamps to 4; slot 3 is rewritten to a misclassified sample in the start cycle.
  task automatic test_clamp_same_cycle_write();
    for (int i = 0; i < DEPTH; i++) write_slot(AW'(i), 6'd0, 6'd0, 1'b1);
    run(1'b0, 3'd7, 6'd8, 6'd0, 1'b1, 1'b0);
    compared++; if (r_go !== 12) begin mismatched++; $display("FAIL clamp_go_count got=%0d exp=12", r_go); end
    compared++; if (epochs !== 2'd1) begin mismatched++; $display("FAIL clamp_epochs got=%0d exp=1", epochs); end
    compared++; if (last_errors !== 3'd1) begin mismatched++; $display("FAIL same_cycle_write_errors got=%0d exp=1", last_errors); end
    compared++; if (converged !== 1'b0) begin mismatched++; $display("FAIL same_cycle_write_converged got=%b exp=0", converged); end
  endtask

  task automatic test_busy_ignored();
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b1);
    compared++; if (r_fin !== 1) begin mismatched++; $display("FAIL busy_start_pulses got=%0d exp=1", r_fin); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL busy_start_rerun got=%b exp=0", busy); end
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b0);
    compared++; if (last_errors !== 3'd0) begin mismatched++; $display("FAIL busy_write_errors got=%0d exp=0", last_errors); end
  endtask

  task automatic test_protocol();
    nosync_w1 = 1'b1;
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b0);
    nosync_w1 = 1'b0;
    compared++; if (proto_err !== 1'b1) begin mismatched++; $display("FAIL sync_proto_err got=%b exp=1", proto_err); end
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b0);
    compared++; if (proto_err !== 1'b0) begin mismatched++; $display("FAIL proto_err_clear got=%b exp=0", proto_err); end
    stall = 1'b1;
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b0);
    stall = 1'b0;
    compared++; if (r_cycles !== 24) begin mismatched++; $display("FAIL wd_latency got=%0d exp=24", r_cycles); end
    compared++; if (proto_err !== 1'b1) begin mismatched++; $display("FAIL wd_proto_err got=%b exp=1", proto_err); end
    compared++; if (epochs !== 2'd0) begin mismatched++; $display("FAIL wd_epochs got=%0d exp=0", epochs); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    train = 1'b0; num_samples = 3'd1; init_w0 = 6'd8; start = 1'b1;
    repeat (9) begin @(negedge clk); start = 1'b0; end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    reset_l = 1'b0;
    #1;
    compared++;
    if (reset_vec() !== RST_EXP) begin mismatched++; $display("FAIL midrun_reset_outputs got=%h exp=%h", reset_vec(), RST_EXP); end
    compared++; if (w0_out !== 6'd0) begin mismatched++; $display("FAIL midrun_reset_w0_out got=%0d exp=0", w0_out); end
    @(negedge clk);
    reset_l = 1'b1;
    run(1'b0, 3'd1, 6'd8, 6'd0, 1'b0, 1'b0);
    compared++; if (converged !== 1'b1) begin mismatched++; $display("FAIL after_reset_converged got=%b exp=1", converged); end
    compared++; if (epochs !== 2'd1) begin mismatched++; $display("FAIL after_reset_epochs got=%0d exp=1", epochs); end
  endtask

  initial begin
    test_reset();
    test_inference();
    test_training();
    test_non_separable();
    test_zero_samples();
    test_clamp_same_cycle_write();
    test_busy_ignored();
    test_protocol();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
